// File: rtl/sdram_address_sequencer.sv
// Circular-buffer address generator feeding memory_controller with write/read bank/row/column.
// Optional OVERWRITE_OLDEST_EN: a write into a full buffer discards the oldest word instead of being rejected.
module sdram_address_sequencer #(
  parameter logic [23:0] START_ADDR = 24'h000000,
  parameter logic [23:0] END_ADDR   = 24'hFFFFFF
) (
  input  logic        CLK_48MHZ,
  input  logic        RESET,
  input  logic        NEXT_WRITE,
  input  logic        NEXT_READ,
  input  logic        CLEAR_FLAGS,
  output logic [1:0]  BA_WRITE,
  output logic [12:0] ROW_WRITE,
  output logic [8:0]  COL_WRITE,
  output logic [1:0]  BA_READ,
  output logic [12:0] ROW_READ,
  output logic [8:0]  COL_READ,
  output logic [24:0] WORD_COUNT,
  output logic        FULL,
  output logic        EMPTY,
  output logic        OVERFLOW,
  output logic        UNDERFLOW
);

  localparam logic [24:0] CAPACITY = {1'b0, END_ADDR} - {1'b0, START_ADDR} + 25'd1;

  logic [23:0] wr_ptr;
  logic [23:0] rd_ptr;
  logic [24:0] count;
  logic        overflow_flag;
  logic        underflow_flag;

  logic is_full;
  logic is_empty;
  logic rd_ok;
  logic wr_ok;
  logic wr_blocked;
  logic drop_oldest;

  // Wrap is checked before incrementing so the pointer never leaves the region.
  function automatic logic [23:0] advance(input logic [23:0] p);
    return (p == END_ADDR) ? START_ADDR : p + 24'd1;
  endfunction

  always_comb begin
    is_full    = (count == CAPACITY);
    is_empty   = (count == 25'd0);
    rd_ok      = NEXT_READ & ~is_empty;
    wr_blocked = NEXT_WRITE & is_full & ~rd_ok;
`ifdef OVERWRITE_OLDEST_EN
    wr_ok       = NEXT_WRITE;
    drop_oldest = wr_blocked;
`else
    wr_ok       = NEXT_WRITE & ~wr_blocked;
    drop_oldest = 1'b0;
`endif
  end

  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      wr_ptr         <= START_ADDR;
      rd_ptr         <= START_ADDR;
      count          <= 25'd0;
      overflow_flag  <= 1'b0;
      underflow_flag <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= advance(wr_ptr);
      if (rd_ok | drop_oldest)
        rd_ptr <= advance(rd_ptr);
      // A dropped word keeps the count at capacity even though a write was taken.
      if (wr_ok & ~rd_ok & ~drop_oldest)
        count <= count + 25'd1;
      else if (rd_ok & ~wr_ok)
        count <= count - 25'd1;
      overflow_flag  <= (overflow_flag & ~CLEAR_FLAGS) | wr_blocked;
      underflow_flag <= (underflow_flag & ~CLEAR_FLAGS) | (NEXT_READ & is_empty);
    end
  end

  assign COL_WRITE  = wr_ptr[8:0];
  assign ROW_WRITE  = wr_ptr[21:9];
  assign BA_WRITE   = wr_ptr[23:22];
  assign COL_READ   = rd_ptr[8:0];
  assign ROW_READ   = rd_ptr[21:9];
  assign BA_READ    = rd_ptr[23:22];
  assign WORD_COUNT = count;
  assign FULL       = is_full;
  assign EMPTY      = is_empty;
  assign OVERFLOW   = overflow_flag;
  assign UNDERFLOW  = underflow_flag;

endmodule

// File: tb/tb_sdram_address_sequencer.sv
// Bench for sdram_address_sequencer: a full-range instance and a 5..8 instance against a counting model.
module tb_sdram_address_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: default region; instance 1: region 5..8.
  logic rst_b = 1'b1, nw_b = 1'b0, nr_b = 1'b0, clr_b = 1'b0;
  logic rst_s = 1'b1, nw_s = 1'b0, nr_s = 1'b0, clr_s = 1'b0;

  logic [1:0]  ba_w_b, ba_r_b, ba_w_s, ba_r_s;
  logic [12:0] row_w_b, row_r_b, row_w_s, row_r_s;
  logic [8:0]  col_w_b, col_r_b, col_w_s, col_r_s;
  logic [24:0] cnt_b, cnt_s;
  logic        full_b, empty_b, ovf_b, unf_b;
  logic        full_s, empty_s, ovf_s, unf_s;

  sdram_address_sequencer dut_big (
    .CLK_48MHZ(clk), .RESET(rst_b), .NEXT_WRITE(nw_b), .NEXT_READ(nr_b), .CLEAR_FLAGS(clr_b),
    .BA_WRITE(ba_w_b), .ROW_WRITE(row_w_b), .COL_WRITE(col_w_b),
    .BA_READ(ba_r_b), .ROW_READ(row_r_b), .COL_READ(col_r_b),
    .WORD_COUNT(cnt_b), .FULL(full_b), .EMPTY(empty_b), .OVERFLOW(ovf_b), .UNDERFLOW(unf_b)
  );

  sdram_address_sequencer #(.START_ADDR(24'd5), .END_ADDR(24'd8)) dut_small (
    .CLK_48MHZ(clk), .RESET(rst_s), .NEXT_WRITE(nw_s), .NEXT_READ(nr_s), .CLEAR_FLAGS(clr_s),
    .BA_WRITE(ba_w_s), .ROW_WRITE(row_w_s), .COL_WRITE(col_w_s),
    .BA_READ(ba_r_s), .ROW_READ(row_r_s), .COL_READ(col_r_s),
    .WORD_COUNT(cnt_s), .FULL(full_s), .EMPTY(empty_s), .OVERFLOW(ovf_s), .UNDERFLOW(unf_s)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the buffer is described by total accepted writes and total retired words.
  longint m_start [2] = '{0, 5};
  longint m_cap   [2] = '{64'd16777216, 4};
  longint m_nw    [2] = '{0, 0};
  longint m_nr    [2] = '{0, 0};
  bit     m_ovf   [2] = '{0, 0};
  bit     m_unf   [2] = '{0, 0};

  task automatic model_step(input int i, input bit rst, input bit w, input bit r, input bit c);
    longint cnt;
    bit rok, wok;
    if (rst) begin
      m_nw[i] = 0; m_nr[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
      return;
    end
    cnt = m_nw[i] - m_nr[i];
    if (c) begin m_ovf[i] = 0; m_unf[i] = 0; end
    rok = r && (cnt != 0);
    if (r && !rok) m_unf[i] = 1;
    wok = w && ((cnt != m_cap[i]) || rok);
    if (w && !wok) begin
      m_ovf[i] = 1;
`ifdef OVERWRITE_OLDEST_EN
      m_nw[i]++;
      m_nr[i]++;
`endif
    end
    if (rok) m_nr[i]++;
    if (wok) m_nw[i]++;
  endtask

  function automatic longint addr_of(input int i, input longint n);
    return m_start[i] + (n % m_cap[i]);
  endfunction

  always @(posedge clk) begin
    model_step(0, rst_b, nw_b, nr_b, clr_b);
    model_step(1, rst_s, nw_s, nr_s, clr_s);
  end

  task automatic compare_inst(input string p, input int i,
                              input logic [1:0] baw, input logic [12:0] roww, input logic [8:0] colw,
                              input logic [1:0] bar, input logic [12:0] rowr, input logic [8:0] colr,
                              input logic [24:0] cnt, input logic full, input logic empty,
                              input logic ovf, input logic unf);
    logic [23:0] wa, ra;
    longint c;
    wa = 24'(addr_of(i, m_nw[i]));
    ra = 24'(addr_of(i, m_nr[i]));
    c  = m_nw[i] - m_nr[i];
    chk({p, "ba_write"},  baw,  wa[23:22]);
    chk({p, "row_write"}, roww, wa[21:9]);
    chk({p, "col_write"}, colw, wa[8:0]);
    chk({p, "ba_read"},   bar,  ra[23:22]);
    chk({p, "row_read"},  rowr, ra[21:9]);
    chk({p, "col_read"},  colr, ra[8:0]);
    chk({p, "word_count"}, cnt, c);
    chk({p, "full"},  full,  c == m_cap[i]);
    chk({p, "empty"}, empty, c == 0);
    chk({p, "overflow"},  ovf, m_ovf[i]);
    chk({p, "underflow"}, unf, m_unf[i]);
  endtask

  always @(negedge clk) begin
    if (started) begin
      compare_inst("big.", 0, ba_w_b, row_w_b, col_w_b, ba_r_b, row_r_b, col_r_b,
                   cnt_b, full_b, empty_b, ovf_b, unf_b);
      compare_inst("small.", 1, ba_w_s, row_w_s, col_w_s, ba_r_s, row_r_s, col_r_s,
                   cnt_s, full_s, empty_s, ovf_s, unf_s);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_w, exp_r;
    cyc(2);
    rst_b = 1'b0; rst_s = 1'b0;
    started = 1'b1;

    // Reset state, default region.
    chk("rst.col_write", col_w_b, 0);
    chk("rst.row_read", row_r_b, 0);
    chk("rst.ba_write", ba_w_b, 0);
    chk("rst.word_count", cnt_b, 0);
    chk("rst.empty", empty_b, 1);
    chk("rst.full", full_b, 0);
    chk("rst.flags", {ovf_b, unf_b}, 0);

    // 513 writes cross one row boundary.
    nw_b = 1'b1; cyc(513); nw_b = 1'b0;
    chk("w513.col_write", col_w_b, 1);
    chk("w513.row_write", row_w_b, 1);
    chk("w513.ba_write", ba_w_b, 0);
    chk("w513.word_count", cnt_b, 513);
    nr_b = 1'b1; cyc(1); nr_b = 1'b0;
    chk("r1.col_read", col_r_b, 1);
    chk("r1.word_count", cnt_b, 512);

    // Small region: fill, then overfill.
    nw_s = 1'b1; cyc(4); nw_s = 1'b0;
    chk("fill.full", full_s, 1);
    chk("fill.word_count", cnt_s, 4);
    chk("fill.col_write", col_w_s, 5);
    nw_s = 1'b1; cyc(1); nw_s = 1'b0;
    chk("over.overflow", ovf_s, 1);
    chk("over.word_count", cnt_s, 4);
`ifdef OVERWRITE_OLDEST_EN
    exp_w = 6; exp_r = 6;
`else
    exp_w = 5; exp_r = 5;
`endif
    chk("over.col_write", col_w_s, exp_w);
    chk("over.col_read", col_r_s, exp_r);
    clr_s = 1'b1; cyc(1); clr_s = 1'b0;
    chk("clr.overflow", ovf_s, 0);

    // Full with simultaneous read and write: both advance, no overflow.
    nw_s = 1'b1; nr_s = 1'b1; cyc(1); nw_s = 1'b0; nr_s = 1'b0;
    chk("fullrw.col_write", col_w_s, exp_w + 1);
    chk("fullrw.col_read", col_r_s, exp_r + 1);
    chk("fullrw.word_count", cnt_s, 4);
    chk("fullrw.overflow", ovf_s, 0);

    // Drain; pointers meet again after wrapping once.
    nr_s = 1'b1; cyc(4); nr_s = 1'b0;
    chk("drain.empty", empty_s, 1);
    chk("drain.col_read", col_r_s, exp_r + 1);
    nr_s = 1'b1; cyc(1); nr_s = 1'b0;
    chk("badrd.underflow", unf_s, 1);
    chk("badrd.col_read", col_r_s, exp_r + 1);
    clr_s = 1'b1; nr_s = 1'b1; cyc(1); clr_s = 1'b0; nr_s = 1'b0;
    chk("clrset.underflow", unf_s, 1);
    clr_s = 1'b1; cyc(1); clr_s = 1'b0;
    chk("clr.underflow", unf_s, 0);

    // Empty with simultaneous read and write.
    nw_s = 1'b1; nr_s = 1'b1; cyc(1); nw_s = 1'b0; nr_s = 1'b0;
    chk("emptyrw.word_count", cnt_s, 1);
    chk("emptyrw.underflow", unf_s, 1);
    chk("emptyrw.col_write", col_w_s, (exp_w == 5) ? 7 : 8);

    // Reset mid-operation with a concurrent write pulse.
    rst_s = 1'b1; cyc(1); rst_s = 1'b0;
    nw_s = 1'b1; cyc(3);
    rst_s = 1'b1; cyc(1); rst_s = 1'b0; nw_s = 1'b0;
    chk("midrst.word_count", cnt_s, 0);
    chk("midrst.col_write", col_w_s, 5);
    chk("midrst.underflow", unf_s, 0);

    // Randomized traffic on both instances.
    for (int k = 0; k < 3000; k++) begin
      nw_b  = 1'($urandom_range(0, 1));
      nr_b  = 1'($urandom_range(0, 2) == 0);
      clr_b = 1'($urandom_range(0, 15) == 0);
      rst_b = 1'($urandom_range(0, 499) == 0);
      nw_s  = 1'($urandom_range(0, 1));
      nr_s  = 1'($urandom_range(0, 1));
      clr_s = 1'($urandom_range(0, 15) == 0);
      rst_s = 1'($urandom_range(0, 199) == 0);
      cyc(1);
    end
    {nw_b, nr_b, clr_b, rst_b, nw_s, nr_s, clr_s, rst_s} = '0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_address_sequencer.md
# sdram_address_sequencer

Circular-buffer address generator for the SDRAM science-data store. It sits directly upstream of `memory_controller` and supplies its `BA_WRITE`/`COL_WRITE`/`ROW_WRITE` and `BA_READ`/`COL_READ`/`ROW_READ` inputs. It advances the write or read pointer on each `NEXT_WRITE`/`NEXT_READ` pulse returned by `memory_controller`, and tracks fill level, full/empty and sticky overflow/underflow status for telemetry.

## Interface
Parameters:
- `START_ADDR`, default 24'h000000: first linear word address of the buffer region, inclusive.
- `END_ADDR`, default 24'hFFFFFF: last linear word address, inclusive. Must satisfy `START_ADDR` ≤ `END_ADDR`.

Ports:
- `CLK_48MHZ`  in  1  system clock. One clock; all logic on its rising edge.
- `RESET`  in  1  reset; synchronous, active-high.
- `NEXT_WRITE`  in  1  one-cycle pulse: current write address has been consumed.
- `NEXT_READ`  in  1  one-cycle pulse: current read address has been consumed.
- `CLEAR_FLAGS`  in  1  one-cycle pulse; clears `OVERFLOW` and `UNDERFLOW`.
- `BA_WRITE`  out  2  write bank.
- `ROW_WRITE`  out  13  write row.
- `COL_WRITE`  out  9  write column.
- `BA_READ`  out  2  read bank.
- `ROW_READ`  out  13  read row.
- `COL_READ`  out  9  read column.
- `WORD_COUNT`  out  25  number of words written but not yet read.
- `FULL`  out  1  `WORD_COUNT` equals capacity.
- `EMPTY`  out  1  `WORD_COUNT` equals 0.
- `OVERFLOW`  out  1  sticky flag: a write was rejected or overwrote data.
- `UNDERFLOW`  out  1  sticky flag: a read was rejected.

## Operation
- Linear 24-bit address A maps to SDRAM fields as `COL`=A[8:0], `ROW`=A[21:9], `BA`=A[23:22]. Column varies fastest.
- Internal registers:
  - `wr_ptr`, `rd_ptr`: 24 bits each.
  - `count`: 25 bits.
  - Capacity C = `END_ADDR` − `START_ADDR` + 1, computed in 25 bits (maximum 2^24).
- Pointer advance: if ptr == `END_ADDR`, next value is `START_ADDR` (wrap-around); otherwise ptr+1. No intermediate value ever leaves [`START_ADDR`, `END_ADDR`].
- Each cycle, evaluate `wr_ok` and `rd_ok`:
  - `rd_ok` = `NEXT_READ` & (count ≠ 0). A read with count = 0 is ignored and sets `UNDERFLOW`.
  - `wr_ok` = `NEXT_WRITE` & (count ≠ C, or `rd_ok` in the same cycle). Full plus simultaneous read is accepted.
  - A write rejected because the buffer is full is handled as described under Configuration.
- Count update:
  - +1 if `wr_ok` only.
  - −1 if `rd_ok` only.
  - Unchanged if both or neither.
- Empty with `NEXT_WRITE` and `NEXT_READ` in the same cycle: the read is rejected (`UNDERFLOW`=1), the write is accepted, and count becomes 1.
- `FULL`/`EMPTY` are combinational decodes of registered count. They are never both high, since C ≥ 1.
- `CLEAR_FLAGS`: clears both sticky flags. If a flag-setting event occurs in the same cycle, the set wins.
- Reset values:
  - All pointers = `START_ADDR`, so address outputs show `START_ADDR` fields.
  - `WORD_COUNT`=0, `EMPTY`=1, `FULL`=0, `OVERFLOW`=0, `UNDERFLOW`=0.
  - Reset asserted mid-operation discards all state on the next edge. Pulses in that cycle are ignored.

## Timing
- All outputs are registered or derived from registered state only. There is no combinational path from inputs to outputs.
- Latency: a pulse in cycle N produces the updated address, count and flags visible after edge N+1.
- Pulses are accepted back-to-back every cycle. A level held high for k cycles is k advances; the block does no edge detection.
- The advance increment and wrap compare fit one 48 MHz cycle. No pipelining is required.

## Configuration
- `OVERWRITE_OLDEST_EN` undefined (default):
  - A write while full with no concurrent read is rejected.
  - `wr_ptr` and count are unchanged; `OVERFLOW` is set.
- `OVERWRITE_OLDEST_EN` defined:
  - The same write is accepted, and `rd_ptr` advances too, discarding the oldest word.
  - Count stays C; `OVERFLOW` is set.
  - Simultaneous read+write while full behaves as in the default mode.

## Test plan
- Reset, default params -> all BA/ROW/COL outputs 0, `WORD_COUNT`=0, `EMPTY`=1, `FULL`=0, flags 0.
- 513 `NEXT_WRITE` pulses -> `COL_WRITE`=1, `ROW_WRITE`=1, `BA_WRITE`=0, `WORD_COUNT`=513. Then 1 `NEXT_READ` -> `COL_READ`=1, `WORD_COUNT`=512.
- Params 5..8: 4 writes -> `FULL`=1, `WORD_COUNT`=4, `COL_WRITE`=5 (wrapped). A 5th write without the macro -> `OVERFLOW`=1, `COL_WRITE`=5, `COL_READ`=5. With the macro -> `COL_WRITE`=6, `COL_READ`=6, count 4.
- Empty buffer, `NEXT_READ` pulse -> `UNDERFLOW`=1, `COL_READ` unchanged. `CLEAR_FLAGS` -> `UNDERFLOW`=0 after one edge. `CLEAR_FLAGS` with a concurrent bad read -> stays 1.
- Params 5..8, full, simultaneous `NEXT_WRITE`+`NEXT_READ` -> both pointers advance, count 4, `OVERFLOW`=0. Empty plus simultaneous -> count 1, `UNDERFLOW`=1.
- `RESET` asserted after 3 writes, with a write pulse in the same cycle -> count 0, `COL_WRITE`=`START_ADDR` field on the next edge.
